// File: rtl/linear_array_sequencer_if.sv
// Signal bundle between the readout sequencer and its controller / ADC capture side.
// pixel_valid is a strobe with no ready: the consumer must accept one pixel every cycle it is high.
interface linear_array_sequencer_if #(
    parameter int NUM_PIXELS = 128,
    parameter int EXT_W      = 8
);
    localparam int PIX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;

    logic             free_run;
    logic             start;
    logic [EXT_W-1:0] integ_ext;
    logic             serial_out;
    logic             pixel_valid;
    logic [PIX_W-1:0] pixel_index;
    logic             frame_done;
    logic             busy;
    logic [1:0]       dbg_state;

    modport master (
        output free_run, start, integ_ext,
        input  serial_out, pixel_valid, pixel_index, frame_done, busy, dbg_state
    );

    modport slave (
        input  free_run, start, integ_ext,
        output serial_out, pixel_valid, pixel_index, frame_done, busy, dbg_state
    );
endinterface

// File: rtl/linear_array_sequencer.sv
// Linear photodiode array readout sequencer: SI pulse, NUM_PIXELS readout cycles,
// optional integration extension, free-run or triggered operation.
module linear_array_sequencer #(
    parameter int NUM_PIXELS = 128,
    parameter int EXT_W      = 8
) (
    input  logic                   i_sensor_clk,
    input  logic                   i_reset,
    linear_array_sequencer_if.slave io_seq
);
    localparam int PIX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NUM_PIXELS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SI      = 2'd1,
        READOUT = 2'd2,
        INTEG   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PIX_W-1:0] r_pix_cnt;
    logic [PIX_W-1:0] w_pix_nxt;
    logic [EXT_W-1:0] r_ext_cnt;
    logic [EXT_W-1:0] w_ext_cnt_nxt;
    logic [EXT_W-1:0] r_ext_lat;
    logic [EXT_W-1:0] w_ext_lat_nxt;
    logic             w_frame_end;
    logic             r_serial_out;
    logic             r_pixel_valid;
    logic             r_frame_done;
    logic             r_busy;

    always_comb begin
        w_state_nxt   = r_state;
        w_pix_nxt     = '0;
        w_ext_cnt_nxt = r_ext_cnt;
        w_ext_lat_nxt = r_ext_lat;
        w_frame_end   = 1'b0;
        case (r_state)
            IDLE: begin
                if (io_seq.free_run || io_seq.start) begin
                    w_state_nxt = SI;
                end
            end
            SI: begin
                // Extension is frozen here so mid-frame changes only affect the next frame.
                w_ext_lat_nxt = io_seq.integ_ext;
                w_state_nxt   = READOUT;
            end
            READOUT: begin
                if (r_pix_cnt == LAST_PIX) begin
                    if (r_ext_lat != '0) begin
                        w_state_nxt   = INTEG;
                        w_ext_cnt_nxt = r_ext_lat;
                    end else begin
                        w_frame_end = 1'b1;
                    end
                end else begin
                    w_pix_nxt = r_pix_cnt + PIX_W'(1);
                end
            end
            INTEG: begin
                if (r_ext_cnt <= EXT_W'(1)) begin
                    w_frame_end = 1'b1;
                end else begin
                    w_ext_cnt_nxt = r_ext_cnt - EXT_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_frame_end) begin
            w_state_nxt = io_seq.free_run ? SI : IDLE;
        end
    end

    // Outputs are registered from the next-state values so they align with r_state.
    always_ff @(posedge i_sensor_clk) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_pix_cnt     <= '0;
            r_ext_cnt     <= '0;
            r_ext_lat     <= '0;
            r_serial_out  <= 1'b0;
            r_pixel_valid <= 1'b0;
            r_frame_done  <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pix_cnt     <= w_pix_nxt;
            r_ext_cnt     <= w_ext_cnt_nxt;
            r_ext_lat     <= w_ext_lat_nxt;
            r_serial_out  <= (w_state_nxt == SI);
            r_pixel_valid <= (w_state_nxt == READOUT);
            r_frame_done  <= (w_state_nxt == READOUT) && (w_pix_nxt == LAST_PIX);
            r_busy        <= (w_state_nxt != IDLE);
        end
    end

    assign io_seq.serial_out  = r_serial_out;
    assign io_seq.pixel_valid = r_pixel_valid;
    assign io_seq.pixel_index = r_pix_cnt;
    assign io_seq.frame_done  = r_frame_done;
    assign io_seq.busy        = r_busy;
    assign io_seq.dbg_state   = r_state;
endmodule

// File: doc/linear_array_sequencer.md
Name: linear_array_sequencer

Overview:
Parametrised readout sequencer for a linear photodiode sensor array. Generates the one-cycle serial-input (SI) start pulse, then walks the pixel clock through NUM_PIXELS readout cycles with a pixel index and valid strobe for the downstream ADC capture logic. Adds triggered (one-shot) operation, a programmable integration extension between frames, and busy/frame_done status. Sits between the sensor clock domain and the sample-capture/serial-transmit path.

Parameters:
NUM_PIXELS, 128, pixels per frame (>=2)
EXT_W, 8, width of integ_ext input
PIX_W, $clog2(NUM_PIXELS) (localparam), pixel_index width

Ports:
sensor_clk  in  1  sole clock; all logic on rising edge
reset  in  1  synchronous, active-high
free_run  in  1  1 = frames restart back-to-back; 0 = wait for start
start  in  1  one-shot trigger, sampled in IDLE only
integ_ext  in  EXT_W  extra integration cycles appended after readout
serial_out  out  1  SI pulse to sensor, one cycle per frame
pixel_valid  out  1  high during each readout cycle
pixel_index  out  PIX_W  current pixel 0..NUM_PIXELS-1, valid with pixel_valid
frame_done  out  1  one-cycle pulse coincident with last pixel
busy  out  1  high in any state other than IDLE

Behaviour:
- All outputs registered. Reset (sampled high at a rising edge): state=IDLE, serial_out=0, pixel_valid=0, pixel_index=0, frame_done=0, busy=0, pixel/ext counters=0, latched ext=0. Reset overrides every other input, including mid-frame; no partial frame resumes.
- States: IDLE, SI, READOUT, INTEG.
- IDLE: if free_run=1 or start=1 at an edge, go to SI next cycle (1-cycle latency); otherwise stay.
- SI: exactly one cycle; serial_out=1, busy=1. integ_ext latched at this cycle; later changes affect the next frame only. Next state READOUT.
- READOUT: NUM_PIXELS consecutive cycles; pixel_valid=1, pixel_index=0,1,...,NUM_PIXELS-1. frame_done=1 only in the cycle with pixel_index=NUM_PIXELS-1. After the last pixel: if latched ext>0 go to INTEG, else go to end-of-frame decision.
- INTEG: exactly latched-ext cycles; pixel_valid=0, busy=1, pixel_index holds 0.
- End-of-frame decision: free_run=1 -> SI directly (no IDLE cycle); free_run=0 -> IDLE.
- Frame period in free-run = 1 + NUM_PIXELS + integ_ext. Default (128, ext=0) = 129 cycles, SI every 129th cycle.
- start while busy=1 ignored (not queued). start and free_run both high in IDLE: single SI, behaves as free-run.
- free_run dropped mid-frame: current frame completes including INTEG, then IDLE.
- pixel_index returns to 0 outside READOUT; pixel_valid never high in SI, INTEG or IDLE.
- Counter widths: pixel counter PIX_W bits, compared to NUM_PIXELS-1 (no wrap past it); ext counter EXT_W bits, max ext = 2^EXT_W-1 with no overflow.

Test Plan:
1. Defaults, free_run=1, integ_ext=0 after reset -> serial_out high 1 cycle after reset release, then every 129 cycles; 128 pixel_valid cycles, index 0..127, frame_done on index 127.
2. free_run=0, start pulse 1 cycle -> serial_out next cycle, 128 valid pixels, frame_done, then busy=0 and IDLE; no further SI without start.
3. free_run=1, integ_ext=5 -> period 134 cycles, 5 gap cycles with pixel_valid=0 and busy=1; change integ_ext to 0 mid-readout -> current frame still 134, next 129.
4. start pulsed at pixel_index=40 of triggered frame -> ignored; exactly one frame produced.
5. reset asserted at pixel_index=60 -> next cycle all outputs 0, state IDLE; with free_run=1, SI one cycle after release and index restarts at 0.
6. NUM_PIXELS=4, EXT_W=2, integ_ext=3, free_run=1 -> period 8: SI, index 0..3, frame_done on 3, 3 idle-integration cycles, SI.
